lc3_datapath_gen: RTL and testbench

Parametrised LC-3 datapath: PC, MAR, MDR, IR, register file, ALU, address adder, NZP condition codes and BEN, all sharing one gated internal bus. It sits between the control FSM, which supplies the per-cycle control word, and the memory/I-O subsystem, which it drives through a request/acknowledge handshake so memory may insert wait states. Data width and register count are generic; instruction decode stays LC-3.

---
 rtl/lc3_pkg.sv | 34 +++
 rtl/lc3_regfile.sv | 32 +++
 rtl/lc3_datapath_gen.sv | 226 ++++++++++++++++++++++
 tb/tb_lc3_datapath_gen.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared types and constants for the LC-3 datapath slice.
package lc3_pkg;

   typedef enum logic [1:0] {
      PC_INC   = 2'b00,
      PC_BUS   = 2'b01,
      PC_ADDER = 2'b10,
      PC_HOLD  = 2'b11
   } pcmux_t;

   typedef enum logic [1:0] {
      A2_ZERO  = 2'b00,
      A2_OFF6  = 2'b01,
      A2_OFF9  = 2'b10,
      A2_OFF11 = 2'b11
   } addr2mux_t;

   typedef enum logic [1:0] {
      ALU_ADD  = 2'b00,
      ALU_AND  = 2'b01,
      ALU_NOT  = 2'b10,
      ALU_PASS = 2'b11
   } aluk_t;

   typedef enum logic [1:0] {
      MS_IDLE    = 2'b00,
      MS_RD_WAIT = 2'b01,
      MS_WR_WAIT = 2'b10
   } mem_state_t;

   localparam logic [2:0] CC_RESET = 3'b010;
   localparam int         R7_IDX   = 7;

endpackage

// File: rtl/lc3_regfile.sv
// LC-3 register file: one synchronous write port, two asynchronous read ports.
// A read of the register being written returns the pre-edge value.
module lc3_regfile #(
   parameter int W    = 16,
   parameter int NREG = 8,
   parameter int AW   = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic [AW-1:0] raddr1_i,
   input  logic [AW-1:0] raddr2_i,
   output logic [W-1:0]  rdata1_o,
   output logic [W-1:0]  rdata2_o
);

   logic [W-1:0] regs_q [NREG];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else if (we_i) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata1_o = regs_q[raddr1_i];
   assign rdata2_o = regs_q[raddr2_i];

endmodule

// File: rtl/lc3_datapath_gen.sv
// Parametrised LC-3 datapath with a shared gated bus and a wait-state memory handshake.
// Build option: DATAPATH_BUS_CHECK_EN (OR-ed bus plus sticky bus_err on gate contention).
//
// state      | meaning
// MS_IDLE    | no memory transaction; accepts mem_rd / mem_wr pulses
// MS_RD_WAIT | read outstanding; mem_ce=1, waiting for mem_ack to capture mem_rdata
// MS_WR_WAIT | write outstanding; mem_ce=mem_we=1, waiting for mem_ack
module lc3_datapath_gen
   import lc3_pkg::*;
#(
   parameter int W    = 16,
   parameter int NREG = 8
) (
   input  logic         Clk,
   input  logic         Reset_n,
   input  logic         LD_MAR,
   input  logic         LD_MDR,
   input  logic         LD_IR,
   input  logic         LD_BEN,
   input  logic         LD_CC,
   input  logic         LD_REG,
   input  logic         LD_PC,
   input  logic         GatePC,
   input  logic         GateMDR,
   input  logic         GateALU,
   input  logic         GateMARMUX,
   input  logic [1:0]   PCMUX,
   input  logic         DRMUX,
   input  logic         SR1MUX,
   input  logic         SR2MUX,
   input  logic         ADDR1MUX,
   input  logic [1:0]   ADDR2MUX,
   input  logic [1:0]   ALUK,
   input  logic         MIO_EN,
   input  logic         mem_rd,
   input  logic         mem_wr,
   input  logic         mem_ack,
   input  logic [W-1:0] mem_rdata,
   output logic         mem_ce,
   output logic         mem_we,
   output logic [W-1:0] mem_addr,
   output logic [W-1:0] mem_wdata,
   output logic         mem_busy,
   output logic         BEN,
   output logic [W-1:0] MAR,
   output logic [W-1:0] MDR,
   output logic [W-1:0] IR,
   output logic [W-1:0] PC,
   output logic         bus_err
);

   localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;
   localparam logic [AW-1:0] R7_A = AW'(R7_IDX);

   logic [W-1:0] pc_q, pc_d, mar_q, mar_d, mdr_q, mdr_d, ir_q, ir_d;
   logic [2:0]   cc_q, cc_d;
   logic         ben_q, ben_d;
   mem_state_t   state_q, state_d;

   logic [W-1:0] bus, alu_out, adder_out, addr1, addr2, sr2_val;
   logic [W-1:0] sr1_rd, sr2_rd;
   logic [W-1:0] imm5, off6, off9, off11;
   logic [AW-1:0] dr_a, sr1_a, sr2_a;
   logic         rd_done;
   logic         bus_n, bus_z;
   logic         unused_ir;

   assign imm5  = {{(W-5){ir_q[4]}},   ir_q[4:0]};
   assign off6  = {{(W-6){ir_q[5]}},   ir_q[5:0]};
   assign off9  = {{(W-9){ir_q[8]}},   ir_q[8:0]};
   assign off11 = {{(W-11){ir_q[10]}}, ir_q[10:0]};
   assign unused_ir = ^ir_q;

   assign dr_a  = DRMUX  ? R7_A : ir_q[9 +: AW];
   assign sr1_a = SR1MUX ? ir_q[6 +: AW] : ir_q[9 +: AW];
   assign sr2_a = ir_q[0 +: AW];

   lc3_regfile #(.W(W), .NREG(NREG), .AW(AW)) u_regfile (
      .clk      (Clk),
      .rst_n    (Reset_n),
      .we_i     (LD_REG),
      .waddr_i  (dr_a),
      .wdata_i  (bus),
      .raddr1_i (sr1_a),
      .raddr2_i (sr2_a),
      .rdata1_o (sr1_rd),
      .rdata2_o (sr2_rd)
   );

   assign sr2_val = SR2MUX ? imm5 : sr2_rd;
   assign addr1   = ADDR1MUX ? sr1_rd : pc_q;

   always_comb begin
      addr2 = '0;
      case (addr2mux_t'(ADDR2MUX))
         A2_ZERO:  addr2 = '0;
         A2_OFF6:  addr2 = off6;
         A2_OFF9:  addr2 = off9;
         A2_OFF11: addr2 = off11;
         default:  addr2 = '0;
      endcase
   end

   assign adder_out = addr1 + addr2;

   always_comb begin
      alu_out = sr1_rd;
      case (aluk_t'(ALUK))
         ALU_ADD:  alu_out = sr1_rd + sr2_val;
         ALU_AND:  alu_out = sr1_rd & sr2_val;
         ALU_NOT:  alu_out = ~sr1_rd;
         ALU_PASS: alu_out = sr1_rd;
         default:  alu_out = sr1_rd;
      endcase
   end

`ifdef DATAPATH_BUS_CHECK_EN
   logic bus_err_q, bus_err_d;

   assign bus = ({W{GatePC}}     & pc_q)
              | ({W{GateMDR}}    & mdr_q)
              | ({W{GateALU}}    & alu_out)
              | ({W{GateMARMUX}} & adder_out);

   assign bus_err_d = bus_err_q
                    | ($countones({GatePC, GateMDR, GateALU, GateMARMUX}) > 1);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) bus_err_q <= 1'b0;
      else          bus_err_q <= bus_err_d;
   end

   assign bus_err = bus_err_q;
`else
   always_comb begin
      bus = '0;
      if (GatePC)          bus = pc_q;
      else if (GateMDR)    bus = mdr_q;
      else if (GateALU)    bus = alu_out;
      else if (GateMARMUX) bus = adder_out;
   end

   assign bus_err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      mem_ce  = 1'b0;
      mem_we  = 1'b0;
      case (state_q)
         MS_IDLE: begin
            if (mem_rd)      state_d = MS_RD_WAIT;
            else if (mem_wr) state_d = MS_WR_WAIT;
         end
         MS_RD_WAIT: begin
            mem_ce = 1'b1;
            if (mem_ack) state_d = MS_IDLE;
         end
         MS_WR_WAIT: begin
            mem_ce = 1'b1;
            mem_we = 1'b1;
            if (mem_ack) state_d = MS_IDLE;
         end
         default: state_d = MS_IDLE;
      endcase
   end

   assign rd_done = (state_q == MS_RD_WAIT) && mem_ack;

   // Read completion beats a same-cycle bus load of MDR.
   always_comb begin
      mdr_d = mdr_q;
      if (rd_done && (MIO_EN || LD_MDR)) mdr_d = mem_rdata;
      else if (LD_MDR && !MIO_EN)        mdr_d = bus;
   end

   always_comb begin
      pc_d = pc_q;
      if (LD_PC) begin
         case (pcmux_t'(PCMUX))
            PC_INC:   pc_d = pc_q + W'(1);
            PC_BUS:   pc_d = bus;
            PC_ADDER: pc_d = adder_out;
            PC_HOLD:  pc_d = pc_q;
            default:  pc_d = pc_q;
         endcase
      end
   end

   assign bus_n = bus[W-1];
   assign bus_z = (bus == '0);
   assign cc_d  = LD_CC  ? {bus_n, bus_z, !bus_n && !bus_z} : cc_q;
   assign ben_d = LD_BEN ? |(ir_q[11:9] & cc_q) : ben_q;
   assign mar_d = LD_MAR ? bus : mar_q;
   assign ir_d  = LD_IR  ? bus : ir_q;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         pc_q    <= '0;
         mar_q   <= '0;
         mdr_q   <= '0;
         ir_q    <= '0;
         cc_q    <= CC_RESET;
         ben_q   <= 1'b0;
         state_q <= MS_IDLE;
      end else begin
         pc_q    <= pc_d;
         mar_q   <= mar_d;
         mdr_q   <= mdr_d;
         ir_q    <= ir_d;
         cc_q    <= cc_d;
         ben_q   <= ben_d;
         state_q <= state_d;
      end
   end

   assign mem_busy  = (state_q != MS_IDLE);
   assign mem_addr  = mar_q;
   assign mem_wdata = mdr_q;
   assign BEN       = ben_q;
   assign MAR       = mar_q;
   assign MDR       = mdr_q;
   assign IR        = ir_q;
   assign PC        = pc_q;

endmodule

// File: tb/tb_lc3_datapath_gen.sv
// Scoreboard bench for lc3_datapath_gen; honours DATAPATH_BUS_CHECK_EN when defined.
module tb_lc3_datapath_gen;
   import lc3_pkg::*;

   localparam int W = 16;

   logic Clk = 1'b0;
   logic Reset_n;
   logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC;
   logic GatePC, GateMDR, GateALU, GateMARMUX;
   logic [1:0] PCMUX, ADDR2MUX, ALUK;
   logic DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN;
   logic mem_rd, mem_wr, mem_ack;
   logic [W-1:0] mem_rdata;
   logic mem_ce, mem_we, mem_busy, BEN, bus_err;
   logic [W-1:0] mem_addr, mem_wdata, MAR, MDR, IR, PC;

   int n_cmp = 0;
   int n_err = 0;
   logic [W-1:0] sb_q[$];
   logic [W-1:0] exp_v, obs_v;
   logic [2:0]   nzp;
   logic [W-1:0] pc_m;

   lc3_datapath_gen #(.W(W), .NREG(8)) dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
      .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC),
      .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
      .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
      .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK), .MIO_EN(MIO_EN),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_busy(mem_busy), .BEN(BEN), .MAR(MAR), .MDR(MDR), .IR(IR), .PC(PC),
      .bus_err(bus_err)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic clr();
      {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC} = '0;
      {GatePC, GateMDR, GateALU, GateMARMUX} = '0;
      PCMUX = 2'b11; ADDR2MUX = 2'b00; ALUK = 2'b00;
      {DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN} = '0;
      {mem_rd, mem_wr, mem_ack} = '0;
      mem_rdata = '0;
   endtask

   task automatic load_mdr(input logic [W-1:0] v);
      clr(); mem_rd = 1'b1; MIO_EN = 1'b1;
      tick();
      mem_rd = 1'b0; mem_ack = 1'b1; mem_rdata = v;
      tick();
      clr();
   endtask

   task automatic load_ir(input logic [W-1:0] v);
      load_mdr(v);
      GateMDR = 1'b1; LD_IR = 1'b1;
      tick();
      clr();
   endtask

   // Observes CC through BEN, one condition bit per probe instruction.
   task automatic read_cc(output logic [2:0] cc);
      logic [W-1:0] probe [3];
      probe[0] = 16'h0800; probe[1] = 16'h0400; probe[2] = 16'h0200;
      for (int i = 0; i < 3; i++) begin
         load_ir(probe[i]);
         LD_BEN = 1'b1;
         tick();
         clr();
         cc[2-i] = BEN;
      end
   endtask

   task automatic read_reg(input int idx, output logic [W-1:0] v);
      load_ir(W'(idx) << 9);
      GateALU = 1'b1; ALUK = ALU_PASS; SR1MUX = 1'b0; LD_MAR = 1'b1;
      tick();
      clr();
      v = MAR;
   endtask

   task automatic test_reset();
      clr(); Reset_n = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      sb_q.push_back('0); sb_q.push_back('0); sb_q.push_back('0); sb_q.push_back('0);
      sb_q.push_back('0); sb_q.push_back('0);
      exp_v = sb_q.pop_front(); n_cmp++;
      if (PC !== exp_v) begin n_err++; $display("FAIL reset_pc: got %h want %h", PC, exp_v); end
      exp_v = sb_q.pop_front(); n_cmp++;
      if (MAR !== exp_v) begin n_err++; $display("FAIL reset_mar: got %h want %h", MAR, exp_v); end
      exp_v = sb_q.pop_front(); n_cmp++;
      if (MDR !== exp_v) begin n_err++; $display("FAIL reset_mdr: got %h want %h", MDR, exp_v); end
      exp_v = sb_q.pop_front(); n_cmp++;
      if (IR !== exp_v) begin n_err++; $display("FAIL reset_ir: got %h want %h", IR, exp_v); end
      exp_v = sb_q.pop_front(); n_cmp++;
      obs_v = {12'b0, BEN, mem_ce, mem_we, mem_busy};
      if (obs_v !== exp_v) begin n_err++; $display("FAIL reset_flags: got %h want %h", obs_v, exp_v); end
      exp_v = sb_q.pop_front(); n_cmp++;
      if ({15'b0, bus_err} !== exp_v) begin n_err++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
      Reset_n = 1'b1;
      tick();
      GatePC = 1'b1; LD_MAR = 1'b1; PCMUX = 2'b00; LD_PC = 1'b1;
      sb_q.push_back(16'h0000); sb_q.push_back(16'h0001);
      tick();
      clr();
      pc_m = 16'h0001;
      exp_v = sb_q.pop_front(); n_cmp++;
      if (MAR !== exp_v) begin n_err++; $display("FAIL fetch_mar: got %h want %h", MAR, exp_v); end
      exp_v = sb_q.pop_front(); n_cmp++;
      if (PC !== exp_v) begin n_err++; $display("FAIL fetch_pc: got %h want %h", PC, exp_v); end
      sb_q.push_back(16'h0002);
      read_cc(nzp);
      exp_v = sb_q.pop_front(); n_cmp++;
      if ({13'b0, nzp} !== exp_v) begin n_err++; $display("FAIL reset_cc: got %b want %b", nzp, exp_v[2:0]); end
   endtask

   task automatic test_ben();
      logic [W-1:0] irs [2];
      irs[0] = 16'h0400; irs[1] = 16'h0A00;
      for (int i = 0; i < 2; i++) begin
         sb_q.push_back((i == 0) ? 16'h0001 : 16'h0000);
         load_ir(irs[i]);
         LD_BEN = 1'b1;
         tick();
         clr();
         exp_v = sb_q.pop_front(); n_cmp++;
         if ({15'b0, BEN} !== exp_v) begin
            n_err++; $display("FAIL ben_ir_%h: got %b want %b", irs[i], BEN, exp_v[0]);
         end
      end
   endtask

   task automatic test_pc_adder();
      load_ir(16'h0005);
      ADDR1MUX = 1'b0; ADDR2MUX = A2_OFF9; PCMUX = PC_ADDER; LD_PC = 1'b1;
      pc_m = pc_m + 16'd5;
      sb_q.push_back(pc_m);
      tick(); clr();
      exp_v = sb_q.pop_front(); n_cmp++;
      if (PC !== exp_v) begin n_err++; $display("FAIL pc_off9: got %h want %h", PC, exp_v); end
      GateMARMUX = 1'b1; ADDR1MUX = 1'b0; ADDR2MUX = A2_OFF9; LD_MAR = 1'b1;
      sb_q.push_back(pc_m + 16'd5);
      tick(); clr();
      exp_v = sb_q.pop_front(); n_cmp++;
      if (MAR !== exp_v) begin n_err++; $display("FAIL marmux_off9: got %h want %h", MAR, exp_v); end
      load_ir(16'h07FF);
      ADDR2MUX = A2_OFF11; PCMUX = PC_ADDER; LD_PC = 1'b1;
      pc_m = pc_m - 16'd1;
      sb_q.push_back(pc_m);
      tick(); clr();
      exp_v = sb_q.pop_front(); n_cmp++;
      if (PC !== exp_v) begin n_err++; $display("FAIL pc_off11_neg: got %h want %h", PC, exp_v); end
   endtask

   task automatic test_read_wait();
      int busy_cnt, ce_cnt, we_seen;
      busy_cnt = 0; ce_cnt = 0; we_seen = 0;
      sb_q.push_back(16'd4); sb_q.push_back(16'd4); sb_q.push_back(16'd0); sb_q.push_back(16'h1234);
      clr(); mem_rd = 1'b1; MIO_EN = 1'b1;
      tick();
      mem_rd = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         if (mem_busy) busy_cnt++;
         if (mem_ce) ce_cnt++;
         if (mem_we) we_seen++;
         mem_ack   = (c == 4);
         mem_rdata = (c == 4) ? 16'h1234 : 16'hDEAD;
         tick();
      end
      clr();
      exp_v = sb_q.pop_front(); n_cmp++;
      if (W'(busy_cnt) !== exp_v) begin n_err++; $display("FAIL rd_busy_cycles: got %0d want %0d", busy_cnt, exp_v); end
      exp_v = sb_q.pop_front(); n_cmp++;
      if (W'(ce_cnt) !== exp_v) begin n_err++; $display("FAIL rd_ce_cycles: got %0d want %0d", ce_cnt, exp_v); end
      exp_v = sb_q.pop_front(); n_cmp++;
      if (W'(we_seen) !== exp_v) begin n_err++; $display("FAIL rd_we_cycles: got %0d want %0d", we_seen, exp_v); end
      exp_v = sb_q.pop_front(); n_cmp++;
      if (MDR !== exp_v) begin n_err++; $display("FAIL rd_mdr: got %h want %h", MDR, exp_v); end
   endtask

   task automatic test_simul_rdwr();
      int we_seen;
      we_seen = 0;
      sb_q.push_back(16'd0); sb_q.push_back(16'hBEEF);
      clr(); mem_rd = 1'b1; mem_wr = 1'b1; MIO_EN = 1'b1;
      tick();
      mem_rd = 1'b0; mem_wr = 1'b0;
      if (mem_we) we_seen++;
      mem_ack = 1'b1; mem_rdata = 16'hBEEF;
      tick();
      mem_ack = 1'b0;
      for (int c = 0; c < 3; c++) begin
         if (mem_we) we_seen++;
         tick();
      end
      clr();
      exp_v = sb_q.pop_front(); n_cmp++;
      if (W'(we_seen) !== exp_v) begin n_err++; $display("FAIL rdwr_we_cycles: got %0d want %0d", we_seen, exp_v); end
      exp_v = sb_q.pop_front(); n_cmp++;
      if (MDR !== exp_v) begin n_err++; $display("FAIL rdwr_mdr: got %h want %h", MDR, exp_v); end
   endtask

   task automatic test_write();
      sb_q.push_back(16'hBEEF);
      clr(); LD_MDR = 1'b1; MIO_EN = 1'b1; mem_rdata = 16'h4444;
      tick(); clr();
      exp_v = sb_q.pop_front(); n_cmp++;
      if (MDR !== exp_v) begin n_err++; $display("FAIL mdr_mio_idle: got %h want %h", MDR, exp_v); end
      sb_q.push_back({14'b0, 2'b11}); sb_q.push_back(16'hBEEF); sb_q.push_back({14'b0, 2'b11});
      sb_q.push_back(16'h0000); sb_q.push_back(16'hBEEF);
      mem_wr = 1'b1;
      tick();
      mem_wr = 1'b0;
      exp_v = sb_q.pop_front(); n_cmp++;
      if ({14'b0, mem_ce, mem_we} !== exp_v) begin n_err++; $display("FAIL wr_strobes: got %b%b want 11", mem_ce, mem_we); end
      exp_v = sb_q.pop_front(); n_cmp++;
      if (mem_wdata !== exp_v) begin n_err++; $display("FAIL wr_wdata: got %h want %h", mem_wdata, exp_v); end
      mem_rd = 1'b1; MIO_EN = 1'b1;
      tick();
      mem_rd = 1'b0;
      tick();
      exp_v = sb_q.pop_front(); n_cmp++;
      if ({14'b0, mem_ce, mem_we} !== exp_v) begin n_err++; $display("FAIL wr_ignore_rd: got %b%b want 11", mem_ce, mem_we); end
      mem_ack = 1'b1; mem_rdata = 16'h7777;
      tick();
      clr();
      exp_v = sb_q.pop_front(); n_cmp++;
      if ({15'b0, mem_busy} !== exp_v) begin n_err++; $display("FAIL wr_done_busy: got %b want 0", mem_busy); end
      exp_v = sb_q.pop_front(); n_cmp++;
      if (MDR !== exp_v) begin n_err++; $display("FAIL wr_mdr_kept: got %h want %h", MDR, exp_v); end
   endtask

   task automatic test_alu();
      load_ir(16'h0200);
      load_mdr(16'h7FFF);
      GateMDR = 1'b1; LD_REG = 1'b1;
      tick(); clr();
      load_ir(16'h1461);
      SR1MUX = 1'b1; SR2MUX = 1'b1; ALUK = ALU_ADD; GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
      sb_q.push_back(16'h8000); sb_q.push_back(16'h0004);
      tick(); clr();
      read_reg(2, obs_v);
      exp_v = sb_q.pop_front(); n_cmp++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL add_r2: got %h want %h", obs_v, exp_v); end
      read_cc(nzp);
      exp_v = sb_q.pop_front(); n_cmp++;
      if ({13'b0, nzp} !== exp_v) begin n_err++; $display("FAIL add_cc: got %b want %b", nzp, exp_v[2:0]); end
      load_ir(16'h96BF);
      SR1MUX = 1'b1; ALUK = ALU_NOT; GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
      sb_q.push_back(16'h7FFF); sb_q.push_back(16'h0001);
      tick(); clr();
      read_reg(3, obs_v);
      exp_v = sb_q.pop_front(); n_cmp++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL not_r3: got %h want %h", obs_v, exp_v); end
      read_cc(nzp);
      exp_v = sb_q.pop_front(); n_cmp++;
      if ({13'b0, nzp} !== exp_v) begin n_err++; $display("FAIL not_cc: got %b want %b", nzp, exp_v[2:0]); end
      load_ir(16'h50C2);
      SR1MUX = 1'b1; SR2MUX = 1'b0; ALUK = ALU_AND; GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
      sb_q.push_back(16'h0002);
      tick(); clr();
      read_cc(nzp);
      exp_v = sb_q.pop_front(); n_cmp++;
      if ({13'b0, nzp} !== exp_v) begin n_err++; $display("FAIL and_reg_cc: got %b want %b", nzp, exp_v[2:0]); end
      load_ir(16'h58EF);
      SR1MUX = 1'b1; SR2MUX = 1'b1; ALUK = ALU_AND; GateALU = 1'b1; LD_REG = 1'b1; DRMUX = 1'b1;
      sb_q.push_back(16'h000F); sb_q.push_back(16'h0000);
      tick(); clr();
      read_reg(7, obs_v);
      exp_v = sb_q.pop_front(); n_cmp++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL and_imm_r7: got %h want %h", obs_v, exp_v); end
      read_reg(4, obs_v);
      exp_v = sb_q.pop_front(); n_cmp++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL drmux_r4_untouched: got %h want %h", obs_v, exp_v); end
   endtask

   task automatic test_bus();
      load_ir(16'h0600);
      GatePC = 1'b1; GateALU = 1'b1; ALUK = ALU_PASS; SR1MUX = 1'b0; LD_MAR = 1'b1;
`ifdef DATAPATH_BUS_CHECK_EN
      sb_q.push_back(pc_m | 16'h7FFF); sb_q.push_back(16'h0001); sb_q.push_back(16'h0001);
`else
      sb_q.push_back(pc_m); sb_q.push_back(16'h0000); sb_q.push_back(16'h0000);
`endif
      tick(); clr();
      exp_v = sb_q.pop_front(); n_cmp++;
      if (MAR !== exp_v) begin n_err++; $display("FAIL contention_bus: got %h want %h", MAR, exp_v); end
      exp_v = sb_q.pop_front(); n_cmp++;
      if ({15'b0, bus_err} !== exp_v) begin n_err++; $display("FAIL bus_err_set: got %b want %b", bus_err, exp_v[0]); end
      GatePC = 1'b1; LD_MAR = 1'b1;
      tick(); clr();
      tick();
      exp_v = sb_q.pop_front(); n_cmp++;
      if ({15'b0, bus_err} !== exp_v) begin n_err++; $display("FAIL bus_err_sticky: got %b want %b", bus_err, exp_v[0]); end
   endtask

   task automatic test_reset_mid();
      sb_q.push_back(16'h0000); sb_q.push_back(16'h0000); sb_q.push_back(16'h0000); sb_q.push_back(16'h0000);
      clr(); mem_rd = 1'b1; MIO_EN = 1'b1;
      tick();
      mem_rd = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h5555;
      #1 Reset_n = 1'b0;
      #1;
      exp_v = sb_q.pop_front(); n_cmp++;
      if ({13'b0, mem_ce, mem_we, mem_busy} !== exp_v) begin
         n_err++; $display("FAIL abort_strobes: got ce=%b we=%b busy=%b want 000", mem_ce, mem_we, mem_busy);
      end
      exp_v = sb_q.pop_front(); n_cmp++;
      if (MDR !== exp_v) begin n_err++; $display("FAIL abort_mdr: got %h want %h", MDR, exp_v); end
      #1 Reset_n = 1'b1;
      tick();
      exp_v = sb_q.pop_front(); n_cmp++;
      if ({15'b0, mem_busy} !== exp_v) begin n_err++; $display("FAIL idle_ack_busy: got %b want 0", mem_busy); end
      exp_v = sb_q.pop_front(); n_cmp++;
      if (MDR !== exp_v) begin n_err++; $display("FAIL idle_ack_mdr: got %h want %h", MDR, exp_v); end
      clr();
   endtask

   initial begin
      test_reset();
      test_ben();
      test_pc_adder();
      test_read_wait();
      test_simul_rdwr();
      test_write();
      test_alu();
      test_bus();
      test_reset_mid();
      if (sb_q.size() != 0) begin
         n_cmp++; n_err++;
         $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
